// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register slice: stage occupancy
// states and default widths.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_CTRL_W      = 8;
  localparam int unsigned DEF_STALL_CNT_W = 8;

  // Number of beats currently held by the stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot of a pipeline stage: control bits plus payload with a
// valid flag. clear drops the slot and zeroes its control bits but keeps the
// payload; clear wins over load.
module pipe_stage_entry #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Slot register: reset/clear empties it, load captures a new beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, freeze and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN to build a two-entry
// skid buffer whose in_ready comes only from registered state; by default a
// single entry is used and in_ready follows out_ready combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned CTRL_W      = DEF_CTRL_W,
  parameter int unsigned STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   freeze,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  stage_state_e state;

  logic accept;
  logic release_beat;
  logic head_load;
  logic head_clear;
  logic [CTRL_W-1:0] head_src_ctrl;
  logic [DATA_W-1:0] head_src_data;

  assign accept       = in_valid & in_ready;
  assign release_beat = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_clear;

  // Ready depends only on the registered occupancy, not on out_ready.
  assign in_ready = !freeze & (state != FULL);

  // Head always presents the oldest beat; the skid slot catches a beat that
  // arrives while the head is blocked, and refills the head on release.
  always_comb begin
    head_load     = 1'b0;
    head_clear    = flush;
    skid_load     = 1'b0;
    skid_clear    = flush;
    head_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    head_src_data = skid_valid ? skid_data : in_data;
    unique case (state)
      EMPTY: head_load = accept;
      ONE: begin
        head_load = accept & release_beat;
        skid_load = accept & !release_beat;
        if (release_beat && !accept) head_clear = 1'b1;
      end
      FULL: begin
        head_load = release_beat;
        if (release_beat) skid_clear = 1'b1;
      end
      default: ;
    endcase
  end

  pipe_stage_entry #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .load_ctrl(in_ctrl),
    .load_data(in_data),
    .valid    (skid_valid),
    .ctrl     (skid_ctrl),
    .data     (skid_data)
  );

  // Occupancy FSM for the two-entry buffer; flush empties it from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !release_beat)      state <= FULL;
          else if (release_beat && !accept) state <= EMPTY;
        end
        FULL:    if (release_beat) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end
`else
  // Single entry: a full stage may accept in the same cycle it releases.
  assign in_ready = !freeze & ((state == EMPTY) | out_ready);

  // Load on accept; drop the beat on release unless replaced in that cycle.
  always_comb begin
    head_src_ctrl = in_ctrl;
    head_src_data = in_data;
    head_load     = accept;
    head_clear    = flush | (release_beat & !accept);
  end

  // Occupancy FSM for the single entry; flush empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (accept) state <= ONE;
        ONE:     if (release_beat && !accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end
`endif

  pipe_stage_entry #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_head (
    .clk      (clk),
    .rst      (rst),
    .load     (head_load),
    .clear    (head_clear),
    .load_ctrl(head_src_ctrl),
    .load_data(head_src_data),
    .valid    (out_valid),
    .ctrl     (out_ctrl),
    .data     (out_data)
  );

  // Count consecutive blocked cycles of the head beat, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (flush || release_beat) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
